stopwatch_time_counter: RTL and testbench

// - Stopwatch timekeeping stage. Sits directly downstream of the 10 Hz clock divider and consumes its o_clk as a tick source.
// - Counts MM:SS.t in BCD. Provides run/pause, clear and lap-hold control. Drives BCD digits to the FND display mux.

---
 rtl/stopwatch_time_counter_pkg.sv | 21 ++
 rtl/stopwatch_time_counter_if.sv | 28 ++
 rtl/stopwatch_time_counter_bcd_digit_counter.sv | 26 ++
 rtl/stopwatch_time_counter.sv | 105 ++++++++++
 tb/tb_stopwatch_time_counter.sv | 244 ++++++++++++++++++++++++
 5 files changed

// File: rtl/stopwatch_time_counter_pkg.sv
// Shared constants and types for the stopwatch timekeeping stage:
// FSM state codes, BCD digit terminals and the MM:SS.t digit bundle.
package stopwatch_time_counter_pkg;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] RUN   = 2'd1;
  localparam logic [1:0] PAUSE = 2'd2;
  localparam logic [1:0] LAP   = 2'd3;

  localparam logic [3:0] DIG9 = 4'd9;
  localparam logic [2:0] DIG5 = 3'd5;

  typedef struct packed {
    logic [3:0] min_tens;
    logic [3:0] min_ones;
    logic [2:0] sec_tens;
    logic [3:0] sec_ones;
    logic [3:0] tenths;
  } sw_time_t;

endpackage

// File: rtl/stopwatch_time_counter_if.sv
// Control pulses in, BCD display digits and status out; the driver side
// (button logic / bench) uses master, the timekeeping stage uses slave.
interface stopwatch_time_counter_if;
  logic       i_tick;
  logic       i_run_stop;
  logic       i_clear;
  logic       i_lap;
  logic [3:0] o_tenths;
  logic [3:0] o_sec_ones;
  logic [2:0] o_sec_tens;
  logic [3:0] o_min_ones;
  logic [3:0] o_min_tens;
  logic       o_running;
  logic       o_lap_hold;
  logic       o_wrap;

  modport master (
    output i_tick, i_run_stop, i_clear, i_lap,
    input  o_tenths, o_sec_ones, o_sec_tens, o_min_ones, o_min_tens,
    input  o_running, o_lap_hold, o_wrap
  );

  modport slave (
    input  i_tick, i_run_stop, i_clear, i_lap,
    output o_tenths, o_sec_ones, o_sec_tens, o_min_ones, o_min_tens,
    output o_running, o_lap_hold, o_wrap
  );
endinterface

// File: rtl/stopwatch_time_counter_bcd_digit_counter.sv
// One modulo-(MAX+1) digit of the carry chain; o_carry flags the enabled
// MAX->0 rollover so the next digit can step in the same cycle.
module bcd_digit_counter #(
  parameter int WIDTH = 4,
  parameter int MAX   = 9
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_en,
  input  logic             i_clr,
  output logic [WIDTH-1:0] o_q,
  output logic             o_carry
);

  localparam logic [WIDTH-1:0] Q_MAX = WIDTH'(MAX);

  // NOTE: non-blocking (<=) on all clocked state so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!reset)     o_q <= '0;
    else if (i_clr) o_q <= '0;
    else if (i_en)  o_q <= (o_q == Q_MAX) ? '0 : o_q + 1'b1;
  end

  assign o_carry = i_en & (o_q == Q_MAX);

endmodule

// File: rtl/stopwatch_time_counter.sv
// Stopwatch MM:SS.t BCD timekeeper with run/pause, clear and lap-hold,
// driven by the 10 Hz divider tick and feeding the FND display mux.
module stopwatch_time_counter
  import stopwatch_time_counter_pkg::*;
#(
  parameter bit          TICK_IS_PULSE = 1'b0,
  parameter int unsigned MIN_MAX       = 59
) (
  input logic               clk,
  input logic               reset,
  stopwatch_time_counter_if.slave bus
);

  localparam logic [3:0] MIN_TENS_MAX = 4'(MIN_MAX / 10);
  localparam logic [3:0] MIN_ONES_MAX = 4'(MIN_MAX % 10);

  logic       r_tick_d, tick_ev, count_en, at_terminal, wrap_ev;
  logic       pause_clear, clear_live, snap_load, r_wrap;
  logic [1:0] state, state_nxt;
  logic [3:0] q_tenths, q_sec_ones, q_min_ones, q_min_tens;
  logic [2:0] q_sec_tens;
  logic       c_tenths, c_sec_ones, c_sec_tens, c_min_ones;
  sw_time_t   live, snap, shown;

  // Reset high so a tick already high at reset release is not seen as an edge.
  always_ff @(posedge clk) begin
    if (!reset) r_tick_d <= 1'b1;
    else        r_tick_d <= bus.i_tick;
  end

  assign tick_ev     = TICK_IS_PULSE ? bus.i_tick : (bus.i_tick & ~r_tick_d);
  assign count_en    = tick_ev & ((state == RUN) | (state == LAP));
  assign live        = '{min_tens: q_min_tens, min_ones: q_min_ones, sec_tens: q_sec_tens,
                         sec_ones: q_sec_ones, tenths: q_tenths};
  assign at_terminal = (live.min_tens == MIN_TENS_MAX) & (live.min_ones == MIN_ONES_MAX) &
                       (live.sec_tens == DIG5) & (live.sec_ones == DIG9) & (live.tenths == DIG9);
  assign wrap_ev     = count_en & at_terminal;
  assign pause_clear = (state == PAUSE) & bus.i_clear;
  // The wrap clears every digit explicitly; min_ones need not be 9 at MIN_MAX.
  assign clear_live  = wrap_ev | pause_clear;

  bcd_digit_counter #(.WIDTH(4), .MAX(DIG9)) u_tenths (
    .clk(clk), .reset(reset), .i_en(count_en), .i_clr(clear_live),
    .o_q(q_tenths), .o_carry(c_tenths));
  bcd_digit_counter #(.WIDTH(4), .MAX(DIG9)) u_sec_ones (
    .clk(clk), .reset(reset), .i_en(c_tenths), .i_clr(clear_live),
    .o_q(q_sec_ones), .o_carry(c_sec_ones));
  bcd_digit_counter #(.WIDTH(3), .MAX(DIG5)) u_sec_tens (
    .clk(clk), .reset(reset), .i_en(c_sec_ones), .i_clr(clear_live),
    .o_q(q_sec_tens), .o_carry(c_sec_tens));
  bcd_digit_counter #(.WIDTH(4), .MAX(DIG9)) u_min_ones (
    .clk(clk), .reset(reset), .i_en(c_sec_tens), .i_clr(clear_live),
    .o_q(q_min_ones), .o_carry(c_min_ones));

  // The terminal wrap fires before min_tens can exceed MIN_MAX/10.
  always_ff @(posedge clk) begin
    if (!reset)          q_min_tens <= '0;
    else if (clear_live) q_min_tens <= '0;
    else if (c_min_ones) q_min_tens <= q_min_tens + 4'd1;
  end

  // NOTE: defaults first so every path assigns state_nxt/snap_load and no latch is inferred.
  always_comb begin
    state_nxt = state;
    snap_load = 1'b0;
    case (state)
      IDLE:    if (!bus.i_clear && bus.i_run_stop) state_nxt = RUN;
      RUN:     if (bus.i_run_stop) state_nxt = PAUSE;
               else if (bus.i_lap) begin
                 state_nxt = LAP;
                 snap_load = 1'b1;
               end
      LAP:     if (bus.i_run_stop) state_nxt = PAUSE;
               else if (bus.i_lap) state_nxt = RUN;
      PAUSE:   if (bus.i_clear) state_nxt = IDLE;
               else if (bus.i_run_stop) state_nxt = RUN;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state  <= IDLE;
      snap   <= '0;
      r_wrap <= 1'b0;
    end else begin
      state  <= state_nxt;
      r_wrap <= wrap_ev;
      if (pause_clear)    snap <= '0;
      else if (snap_load) snap <= live;
    end
  end

  // Registered state and digit registers only: no input-to-output path.
  assign shown          = (state == LAP) ? snap : live;
  assign bus.o_tenths   = shown.tenths;
  assign bus.o_sec_ones = shown.sec_ones;
  assign bus.o_sec_tens = shown.sec_tens;
  assign bus.o_min_ones = shown.min_ones;
  assign bus.o_min_tens = shown.min_tens;
  assign bus.o_running  = (state == RUN) | (state == LAP);
  assign bus.o_lap_hold = (state == LAP);
  assign bus.o_wrap     = r_wrap;

endmodule

// File: tb/tb_stopwatch_time_counter.sv
// Bench for stopwatch_time_counter: three instances (square tick / pulse tick /
// pulse tick with MIN_MAX=5) share stimulus; directed table, sequences and a random run.
module tb_stopwatch_time_counter;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic tick = 1'b1, rs = 1'b0, clr = 1'b0, lap = 1'b0;
  always #5 clk = ~clk;

  stopwatch_time_counter_if bus_sq ();
  stopwatch_time_counter_if bus_pl ();
  stopwatch_time_counter_if bus_m5 ();

  stopwatch_time_counter #(.TICK_IS_PULSE(1'b0), .MIN_MAX(59)) u_sq (
    .clk(clk), .reset(reset), .bus(bus_sq));
  stopwatch_time_counter #(.TICK_IS_PULSE(1'b1), .MIN_MAX(59)) u_pl (
    .clk(clk), .reset(reset), .bus(bus_pl));
  stopwatch_time_counter #(.TICK_IS_PULSE(1'b1), .MIN_MAX(5)) u_m5 (
    .clk(clk), .reset(reset), .bus(bus_m5));

  assign bus_sq.i_tick = tick;  assign bus_sq.i_run_stop = rs;
  assign bus_sq.i_clear = clr;  assign bus_sq.i_lap = lap;
  assign bus_pl.i_tick = tick;  assign bus_pl.i_run_stop = rs;
  assign bus_pl.i_clear = clr;  assign bus_pl.i_lap = lap;
  assign bus_m5.i_tick = tick;  assign bus_m5.i_run_stop = rs;
  assign bus_m5.i_clear = clr;  assign bus_m5.i_lap = lap;

  // {min_tens, min_ones, sec_tens, sec_ones, tenths, running, lap_hold, wrap}
  logic [21:0] out_w [3];
  assign out_w[0] = {bus_sq.o_min_tens, bus_sq.o_min_ones, bus_sq.o_sec_tens, bus_sq.o_sec_ones,
                     bus_sq.o_tenths, bus_sq.o_running, bus_sq.o_lap_hold, bus_sq.o_wrap};
  assign out_w[1] = {bus_pl.o_min_tens, bus_pl.o_min_ones, bus_pl.o_sec_tens, bus_pl.o_sec_ones,
                     bus_pl.o_tenths, bus_pl.o_running, bus_pl.o_lap_hold, bus_pl.o_wrap};
  assign out_w[2] = {bus_m5.o_min_tens, bus_m5.o_min_ones, bus_m5.o_sec_tens, bus_m5.o_sec_ones,
                     bus_m5.o_tenths, bus_m5.o_running, bus_m5.o_lap_hold, bus_m5.o_wrap};

  int n_checks = 0;
  int n_err = 0;

  // Reference model: elapsed time as an integer count of tenths.
  typedef enum int {M_IDLE, M_RUN, M_PAUSE, M_LAP} mstate_e;
  bit      m_pulse [3] = '{1'b0, 1'b1, 1'b1};
  int      m_total [3] = '{36000, 36000, 3600};
  int      m_t     [3];
  int      m_snap  [3];
  mstate_e m_st    [3];
  bit      m_prev  [3];
  bit      m_wrap  [3];

  typedef struct {
    bit tick, rs, clr, lap;
    int t;
    bit run, hold, wrap;
  } vec_t;
  vec_t tbl [22];

  function automatic logic [21:0] exp_pack(input int t, input bit run, input bit hold, input bit wrap);
    return {4'(t / 6000), 4'((t / 600) % 10), 3'((t / 100) % 6), 4'((t / 10) % 10), 4'(t % 10),
            run, hold, wrap};
  endfunction

  function automatic logic [21:0] model_exp(input int d);
    return exp_pack((m_st[d] == M_LAP) ? m_snap[d] : m_t[d],
                    (m_st[d] == M_RUN) || (m_st[d] == M_LAP), m_st[d] == M_LAP, m_wrap[d]);
  endfunction

  task automatic model_update(input int d);
    bit ev;
    int old;
    if (!reset) begin
      m_t[d] = 0; m_snap[d] = 0; m_st[d] = M_IDLE; m_prev[d] = 1'b1; m_wrap[d] = 1'b0;
      return;
    end
    ev = m_pulse[d] ? tick : (tick && !m_prev[d]);
    m_prev[d] = tick;
    old = m_t[d];
    m_wrap[d] = 1'b0;
    if (ev && (m_st[d] == M_RUN || m_st[d] == M_LAP)) begin
      if (m_t[d] + 1 == m_total[d]) begin
        m_t[d] = 0;
        m_wrap[d] = 1'b1;
      end else begin
        m_t[d] = m_t[d] + 1;
      end
    end
    case (m_st[d])
      M_IDLE:  if (!clr && rs) m_st[d] = M_RUN;
      M_RUN:   if (rs) m_st[d] = M_PAUSE;
               else if (lap) begin m_st[d] = M_LAP; m_snap[d] = old; end
      M_LAP:   if (rs) m_st[d] = M_PAUSE;
               else if (lap) m_st[d] = M_RUN;
      default: if (clr) begin m_st[d] = M_IDLE; m_t[d] = 0; m_snap[d] = 0; end
               else if (rs) m_st[d] = M_RUN;
    endcase
  endtask

  task automatic check(input string name, input logic [21:0] act, input logic [21:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Apply one cycle of inputs, clock once, then sample 1 time unit after the edge.
  task automatic step(input bit t, input bit r, input bit c, input bit l);
    tick = t; rs = r; clr = c; lap = l;
    @(posedge clk);
    for (int d = 0; d < 3; d++) model_update(d);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    step(1, 0, 0, 0);
    step(1, 0, 0, 0);
    reset = 1'b1;
  endtask

  task automatic sq_ticks(input int n);
    for (int i = 0; i < n; i++) begin
      step(1, 0, 0, 0);
      step(0, 0, 0, 0);
    end
  endtask

  initial begin
    tbl[0]  = '{1, 0, 0, 0, 0, 0, 0, 0};
    tbl[1]  = '{0, 0, 0, 0, 0, 0, 0, 0};
    tbl[2]  = '{1, 0, 0, 0, 0, 0, 0, 0};
    tbl[3]  = '{0, 1, 0, 0, 0, 1, 0, 0};
    tbl[4]  = '{1, 0, 0, 0, 1, 1, 0, 0};
    tbl[5]  = '{0, 0, 1, 0, 1, 1, 0, 0};
    tbl[6]  = '{1, 0, 0, 0, 2, 1, 0, 0};
    tbl[7]  = '{0, 0, 0, 1, 2, 1, 1, 0};
    tbl[8]  = '{1, 0, 0, 0, 2, 1, 1, 0};
    tbl[9]  = '{0, 0, 0, 0, 2, 1, 1, 0};
    tbl[10] = '{1, 0, 0, 0, 2, 1, 1, 0};
    tbl[11] = '{0, 0, 0, 1, 4, 1, 0, 0};
    tbl[12] = '{1, 1, 0, 0, 5, 0, 0, 0};
    tbl[13] = '{0, 0, 0, 0, 5, 0, 0, 0};
    tbl[14] = '{1, 1, 0, 0, 5, 1, 0, 0};
    tbl[15] = '{0, 0, 0, 0, 5, 1, 0, 0};
    tbl[16] = '{1, 0, 0, 0, 6, 1, 0, 0};
    tbl[17] = '{0, 0, 0, 1, 6, 1, 1, 0};
    tbl[18] = '{1, 0, 0, 0, 6, 1, 1, 0};
    tbl[19] = '{0, 1, 0, 0, 7, 0, 0, 0};
    tbl[20] = '{0, 1, 1, 0, 0, 0, 0, 0};
    tbl[21] = '{1, 0, 0, 1, 0, 0, 0, 0};

    do_reset();
    step(1, 0, 0, 0);
    check("reset_release_sq", out_w[0], exp_pack(0, 0, 0, 0));
    check("reset_release_pl", out_w[1], exp_pack(0, 0, 0, 0));

    do_reset();
    for (int i = 0; i < 22; i++) begin
      step(tbl[i].tick, tbl[i].rs, tbl[i].clr, tbl[i].lap);
      check($sformatf("vec%0d", i), out_w[0],
            exp_pack(tbl[i].t, tbl[i].run, tbl[i].hold, tbl[i].wrap));
    end

    // 25 rises -> 00:02.5, each count visible one clock after its rise; then 00:59.9 -> 01:00.0.
    do_reset();
    step(0, 1, 0, 0);
    for (int k = 1; k <= 25; k++) begin
      step(1, 0, 0, 0);
      check($sformatf("tick_%0d", k), out_w[0], exp_pack(k, 1, 0, 0));
      step(0, 0, 0, 0);
    end
    sq_ticks(574);
    check("preload_00_59_9", out_w[0], exp_pack(599, 1, 0, 0));
    step(1, 0, 0, 0);
    check("carry_01_00_0", out_w[0], exp_pack(600, 1, 0, 0));

    // Lap hold at 00:01.0 across 30 ticks, then release shows 00:04.0.
    do_reset();
    step(0, 1, 0, 0);
    sq_ticks(10);
    step(0, 0, 0, 1);
    check("lap_enter", out_w[0], exp_pack(10, 1, 1, 0));
    sq_ticks(30);
    check("lap_frozen", out_w[0], exp_pack(10, 1, 1, 0));
    step(0, 0, 0, 1);
    check("lap_release", out_w[0], exp_pack(40, 1, 0, 0));

    // Clear ignored in RUN; stop with coincident tick; clear beats run_stop in PAUSE.
    do_reset();
    step(0, 1, 0, 0);
    sq_ticks(30);
    step(0, 0, 1, 0);
    check("clear_in_run", out_w[0], exp_pack(30, 1, 0, 0));
    step(1, 1, 0, 0);
    check("stop_with_tick", out_w[0], exp_pack(31, 0, 0, 0));
    step(0, 1, 1, 0);
    check("clear_wins", out_w[0], exp_pack(0, 0, 0, 0));
    step(0, 1, 0, 0);
    check("idle_to_run", out_w[0], exp_pack(0, 1, 0, 0));

    // Pulse-tick instance: reset at 12:34.5, then full wrap from 59:59.9.
    do_reset();
    step(1, 1, 0, 0);
    for (int i = 0; i < 7545; i++) step(1, 0, 0, 0);
    check("pl_12_34_5", out_w[1], exp_pack(7545, 1, 0, 0));
    reset = 1'b0;
    step(1, 0, 0, 0);
    reset = 1'b1;
    check("pl_mid_reset", out_w[1], exp_pack(0, 0, 0, 0));
    step(1, 0, 0, 0);
    check("pl_idle_after_reset", out_w[1], exp_pack(0, 0, 0, 0));
    step(1, 1, 0, 0);
    for (int i = 0; i < 35999; i++) step(1, 0, 0, 0);
    check("pl_59_59_9", out_w[1], exp_pack(35999, 1, 0, 0));
    step(1, 0, 0, 0);
    check("pl_wrap", out_w[1], exp_pack(0, 1, 0, 1));
    step(0, 0, 0, 0);
    check("pl_wrap_one_clk", out_w[1], exp_pack(0, 1, 0, 0));
    step(1, 0, 0, 0);
    check("pl_after_wrap", out_w[1], exp_pack(1, 1, 0, 0));

    // MIN_MAX=5: min_tens stays 0, wrap at 05:59.9.
    do_reset();
    step(1, 1, 0, 0);
    for (int i = 0; i < 3599; i++) step(1, 0, 0, 0);
    check("m5_05_59_9", out_w[2], exp_pack(3599, 1, 0, 0));
    step(1, 0, 0, 0);
    check("m5_wrap", out_w[2], exp_pack(0, 1, 0, 1));

    // Random stimulus against the reference model on all three instances.
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      reset = ($urandom_range(0, 499) != 0);
      step($urandom_range(0, 3) != 0, $urandom_range(0, 19) == 0,
           $urandom_range(0, 11) == 0, $urandom_range(0, 9) == 0);
      for (int d = 0; d < 3; d++)
        check($sformatf("rnd_d%0d_c%0d", d, i), out_w[d], model_exp(d));
    end
    reset = 1'b1;

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
